// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS memory-access stage.
//   - load/store access-size encodings (LM_BYTE/LM_HALF/LM_WORD; 3 behaves as word)
//   - memory-stage FSM state enum
//   - helpers: alignment test and load-data lane select / sign extension
package mips_pkg;

  localparam logic [1:0] LM_BYTE = 2'd0;
  localparam logic [1:0] LM_HALF = 2'd1;
  localparam logic [1:0] LM_WORD = 2'd2;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // True when the access size does not divide the byte lane offset.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] lane);
    logic mis;
    case (mode)
      LM_BYTE: mis = 1'b0;
      LM_HALF: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

  // Pick the addressed byte/half out of a RAM word and sign-extend it.
  function automatic logic [31:0] extend_load(input logic [1:0] mode, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (mode)
      LM_BYTE: r = {{24{b[7]}}, b};
      LM_HALF: r = {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB / hazard outputs of the memory stage.
//   master: upstream pipeline (drives in_*, observes results)
//   slave : mem_stage (consumes in_*, drives branch, stall and wb_* results)
interface mem_stage_if;
  import mips_pkg::*;

  logic        in_zero;
  logic        in_branch;
  logic        in_RegWrite;
  logic        in_MemWrite;
  logic        in_MemRead;
  logic        in_MemToReg;
  logic [1:0]  in_load_mode;
  logic [4:0]  in_writebackDestination;
  logic [31:0] in_aluResult;
  logic [31:0] in_rt;
  logic [31:0] in_pc;

  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic        stall_out;
  logic        misalign_out;
  logic        wb_RegWrite;
  logic        wb_MemToReg;
  logic [4:0]  wb_dest;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_result;

  modport master (
    output in_zero, in_branch, in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg,
           in_load_mode, in_writebackDestination, in_aluResult, in_rt, in_pc,
    input  pc_src_out, branch_target_out, stall_out, misalign_out,
           wb_RegWrite, wb_MemToReg, wb_dest, wb_mem_data, wb_alu_result
  );

  modport slave (
    input  in_zero, in_branch, in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg,
           in_load_mode, in_writebackDestination, in_aluResult, in_rt, in_pc,
    output pc_src_out, branch_target_out, stall_out, misalign_out,
           wb_RegWrite, wb_MemToReg, wb_dest, wb_mem_data, wb_alu_result
  );

endinterface

// File: rtl/data_mem.sv
// data_mem: DEPTH x 32 synchronous-read RAM with per-byte write enable.
//   Write-first: a read in the same cycle as a write returns the new bytes.
//   Ports: clk, we[3:0] byte enables, addr word index, wdata, rdata (registered).
//   Contents are not reset.
module data_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] merged_s;
  logic [31:0] rdata_r;

  // Read word with freshly written lanes substituted (write-first view).
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign merged_s[8*g +: 8] = we[g] ? wdata[8*g +: 8] : mem_r[addr][8*g +: 8];
  end

  // Byte-enabled write and registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_r <= merged_s;
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage.
//   clk, rst_n : pipeline clock, async active-low reset
//   bus        : mem_stage_if.slave - EX/MEM inputs, branch resolution (combinational),
//                stall_out (combinational), misalign_out and MEM/WB wb_* (registered)
// Loads take two cycles (IDLE issues the RAM read and stalls, LOAD_WAIT extends the data);
// stores and other instructions complete in one cycle. Misaligned accesses are dropped
// and reported by a one-cycle misalign_out pulse with writeback disabled.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_stage_if.slave   bus
);

  state_t            state_r, state_n_s;
  logic [1:0]        lane_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic              misaligned_s;
  logic [3:0]        be_s, we_s;
  logic [31:0]       wdata_s, rdata_s;
  logic              stall_s;

  logic              rw_n_s, m2r_n_s, mis_n_s;
  logic [4:0]        dest_n_s;
  logic [31:0]       data_n_s, alu_n_s;

  logic              rw_r, m2r_r, mis_r;
  logic [4:0]        dest_r;
  logic [31:0]       data_r, alu_r;

  // Upper address bits are ignored so addresses wrap modulo DEPTH*4.
  assign lane_s       = bus.in_aluResult[1:0];
  assign word_addr_s  = bus.in_aluResult[ADDR_W+1:2];
  assign misaligned_s = (bus.in_MemRead | bus.in_MemWrite) &
                        is_misaligned(bus.in_load_mode, lane_s);

  assign bus.pc_src_out        = bus.in_branch & bus.in_zero;
  assign bus.branch_target_out = bus.in_pc;
  assign bus.stall_out         = stall_s;

  // Store byte enables and lane-replicated store data for the access size.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = bus.in_rt;
    case (bus.in_load_mode)
      LM_BYTE: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{bus.in_rt[7:0]}};
      end
      LM_HALF: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.in_rt[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = bus.in_rt;
      end
    endcase
  end

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (we_s),
    .addr  (word_addr_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // FSM next state, RAM write strobe, stall and MEM/WB next values.
  always_comb begin
    state_n_s = state_r;
    stall_s   = 1'b0;
    we_s      = 4'b0000;
    rw_n_s    = bus.in_RegWrite;
    m2r_n_s   = bus.in_MemToReg;
    dest_n_s  = bus.in_writebackDestination;
    alu_n_s   = bus.in_aluResult;
    data_n_s  = 32'd0;
    mis_n_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // The store happens here even for a combined store+load; LOAD_WAIT never writes.
        if (bus.in_MemWrite && !misaligned_s) begin
          we_s = be_s;
        end else begin
          we_s = 4'b0000;
        end
        if (misaligned_s) begin
          mis_n_s   = 1'b1;
          rw_n_s    = 1'b0;
          state_n_s = IDLE;
        end else if (bus.in_MemRead) begin
          stall_s   = 1'b1;
          rw_n_s    = 1'b0;
          state_n_s = LOAD_WAIT;
        end else begin
          state_n_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        // Upstream is stalled, so bus inputs still describe the load.
        data_n_s  = extend_load(bus.in_load_mode, lane_s, rdata_s);
        state_n_s = IDLE;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state and MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rw_r    <= 1'b0;
      m2r_r   <= 1'b0;
      dest_r  <= 5'd0;
      data_r  <= 32'd0;
      alu_r   <= 32'd0;
      mis_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      rw_r    <= rw_n_s;
      m2r_r   <= m2r_n_s;
      dest_r  <= dest_n_s;
      data_r  <= data_n_s;
      alu_r   <= alu_n_s;
      mis_r   <= mis_n_s;
    end
  end

  assign bus.wb_RegWrite   = rw_r;
  assign bus.wb_MemToReg   = m2r_r;
  assign bus.wb_dest       = dest_r;
  assign bus.wb_mem_data   = data_r;
  assign bus.wb_alu_result = alu_r;
  assign bus.misalign_out  = mis_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. The driver updates a byte-array memory
// model and queues the expected MEM/WB entry for every clock edge; a monitor pops and
// compares one entry per edge. Combinational outputs are checked by the driver.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int MEMB  = DEPTH * 4;

  typedef struct {
    logic        rd, wr, rw, m2r, br, zero;
    logic [1:0]  mode;
    logic [4:0]  dest;
    logic [31:0] addr, rt, pc;
  } ins_t;

  typedef struct {
    logic        bubble, chk_data, rw, m2r, mis;
    logic [4:0]  dest;
    logic [31:0] alu, data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic [7:0] mb [MEMB];

  mem_stage_if bus ();

  mem_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic rd, input logic wr, input logic rw, input logic m2r,
                              input logic [1:0] mode, input logic [4:0] dest,
                              input logic [31:0] addr, input logic [31:0] rt);
    ins_t t;
    t.rd = rd; t.wr = wr; t.rw = rw; t.m2r = m2r; t.mode = mode; t.dest = dest;
    t.addr = addr; t.rt = rt; t.br = 1'b0; t.zero = 1'b0; t.pc = 32'd0;
    return t;
  endfunction

  task automatic drive(input ins_t t);
    bus.in_MemRead = t.rd;  bus.in_MemWrite = t.wr;  bus.in_RegWrite = t.rw;
    bus.in_MemToReg = t.m2r; bus.in_load_mode = t.mode;
    bus.in_writebackDestination = t.dest; bus.in_aluResult = t.addr;
    bus.in_rt = t.rt; bus.in_pc = t.pc; bus.in_branch = t.br; bus.in_zero = t.zero;
  endtask

  function automatic int size_of(input logic [1:0] mode);
    return (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
  endfunction

  // Issue one instruction, model it, and queue the MEM/WB entries it produces.
  task automatic issue(input ins_t t);
    exp_t e;
    int   sz, ba, off;
    logic mis;
    logic [31:0] v;
    sz  = size_of(t.mode);
    ba  = int'(t.addr % MEMB);
    off = int'(t.addr % 4);
    mis = (t.rd | t.wr) && (off % sz != 0);
    @(negedge clk);
    drive(t);
    #1;
    chk("pc_src", 32'(bus.pc_src_out), 32'(t.br & t.zero));
    chk("br_target", bus.branch_target_out, t.pc);
    if (t.wr && !mis) begin
      for (int k = 0; k < sz; k++) mb[ba + k] = t.rt[8*k +: 8];
    end
    e.dest = t.dest; e.alu = t.addr; e.m2r = t.m2r; e.data = 32'd0;
    if (t.rd && !mis) begin
      chk("stall_load", 32'(bus.stall_out), 32'd1);
      e.bubble = 1'b1; e.chk_data = 1'b0; e.rw = 1'b0; e.mis = 1'b0;
      q.push_back(e);
      v = 32'd0;
      for (int k = 0; k < sz; k++) v = v | (32'(mb[ba + k]) << (8 * k));
      if (sz == 1) v = {{24{v[7]}}, v[7:0]};
      else if (sz == 2) v = {{16{v[15]}}, v[15:0]};
      @(negedge clk);
      #1;
      chk("stall_wait", 32'(bus.stall_out), 32'd0);
      e.bubble = 1'b0; e.chk_data = 1'b1; e.rw = t.rw; e.mis = 1'b0; e.data = v;
      q.push_back(e);
    end else begin
      chk("stall_none", 32'(bus.stall_out), 32'd0);
      e.bubble = 1'b0; e.chk_data = 1'b0; e.rw = t.rw & ~mis; e.mis = mis;
      q.push_back(e);
    end
  endtask

  // Monitor: one MEM/WB entry is produced per clock edge while entries are pending.
  always @(posedge clk) begin
    exp_t e;
    logic bad;
    #2;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      bad = 1'b0;
      if (bus.wb_RegWrite !== e.rw || bus.misalign_out !== e.mis) bad = 1'b1;
      if (!e.bubble && (bus.wb_MemToReg !== e.m2r || bus.wb_dest !== e.dest ||
                        bus.wb_alu_result !== e.alu)) bad = 1'b1;
      if (e.chk_data && bus.wb_mem_data !== e.data) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL wb_entry: got rw=%0b mis=%0b m2r=%0b dest=%0d alu=0x%08h data=0x%08h expected rw=%0b mis=%0b m2r=%0b dest=%0d alu=0x%08h data=0x%08h",
                 bus.wb_RegWrite, bus.misalign_out, bus.wb_MemToReg, bus.wb_dest,
                 bus.wb_alu_result, bus.wb_mem_data, e.rw, e.mis, e.m2r, e.dest, e.alu, e.data);
      end
    end
  end

  initial begin
    ins_t t;
    int   r;
    drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_wb_rw", 32'(bus.wb_RegWrite), 32'd0);
    chk("rst_wb_m2r", 32'(bus.wb_MemToReg), 32'd0);
    chk("rst_wb_dest", 32'(bus.wb_dest), 32'd0);
    chk("rst_wb_data", bus.wb_mem_data, 32'd0);
    chk("rst_wb_alu", bus.wb_alu_result, 32'd0);
    chk("rst_misalign", 32'(bus.misalign_out), 32'd0);
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole memory so every later load has a defined model value.
    for (int i = 0; i < DEPTH; i++) issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0, 32'(i * 4), $urandom()));

    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0, 32'h10, 32'hDEADBEEF));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 5'd9, 32'h10, 32'd0));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd10, 32'h13, 32'd0));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 5'd11, 32'h10, 32'd0));
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'h11, 32'h0000007F));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd12, 32'h11, 32'd0));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 5'd13, 32'h10, 32'd0));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 5'd14, 32'h11, 32'd0));
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0, 32'h12, 32'h12345678));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 5'd15, 32'h10, 32'd0));
    t = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
    t.br = 1'b1; t.zero = 1'b1; t.pc = 32'd128;
    issue(t);
    t.zero = 1'b0;
    issue(t);
    issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 5'd4, 32'h20, 32'd8));
    issue(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 5'd6, 32'h420, 32'd0));

    // Reset while a load waits in LOAD_WAIT.
    @(negedge clk);
    drive(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 5'd3, 32'h10, 32'd0));
    #1;
    chk("rst_mid_stall", 32'(bus.stall_out), 32'd1);
    q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h10, 32'd0});
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
    #1;
    chk("rst_mid_rw", 32'(bus.wb_RegWrite), 32'd0);
    chk("rst_mid_dest", 32'(bus.wb_dest), 32'd0);
    chk("rst_mid_data", bus.wb_mem_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_stall", 32'(bus.stall_out), 32'd0);
    chk("rst_rel_mis", 32'(bus.misalign_out), 32'd0);
    chk("rst_rel_alu", bus.wb_alu_result, 32'd0);
    issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 5'd5, 32'd30, 32'd0));

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 4));
      t = mk(r == 1 || r == 3, r == 2 || r == 3, 1'($urandom()), r == 1 || r == 3,
             2'($urandom_range(0, 3)), 5'($urandom()), $urandom(), $urandom());
      t.br = 1'($urandom()); t.zero = 1'($urandom()); t.pc = $urandom();
      issue(t);
    end

    @(negedge clk); @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs of the execute stage: ALU result, rt, pc, zero, branch, destination and control.
- Performs data-memory loads and stores (byte, half or word) and resolves the branch decision.
- Registers results into the MEM/WB pipeline register for writeback.
- Loads take two cycles through a synchronous-read RAM, so the stage drives a stall to the upstream stages.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory (power of 2).
- ADDR_W, 8, word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_zero  in  1  ALU zero flag.
- in_branch  in  1  branch instruction.
- in_RegWrite  in  1  writeback enable.
- in_MemWrite  in  1  store.
- in_MemRead  in  1  load.
- in_MemToReg  in  1  writeback selects memory data.
- in_load_mode  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- in_writebackDestination  in  5  destination register.
- in_aluResult  in  32  byte address, or ALU value for writeback.
- in_rt  in  32  store data.
- in_pc  in  32  branch target from EX.
- pc_src_out  out  1  branch taken.
- branch_target_out  out  32  next-PC value when taken.
- stall_out  out  1  hold IF/ID/EX and EX/MEM this cycle.
- misalign_out  out  1  misaligned access flag, registered, one-cycle pulse.
- wb_RegWrite  out  1  registered writeback enable.
- wb_MemToReg  out  1  registered writeback mux select.
- wb_dest  out  5  registered destination register.
- wb_mem_data  out  32  registered extended load data.
- wb_alu_result  out  32  registered ALU result.

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE.
  - Every registered output is 0: wb_RegWrite, wb_MemToReg, wb_dest, wb_mem_data, wb_alu_result, misalign_out.
  - Combinational outputs follow their equations: pc_src_out, branch_target_out, stall_out.
  - Memory contents are not reset.
- Branch resolution:
  - pc_src_out = in_branch & in_zero.
  - branch_target_out = in_pc.
  - Both are combinational and independent of the FSM.
- Address handling:
  - Word index = in_aluResult[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = in_aluResult[1:0].
- Misaligned access:
  - Defined as half with addr[0] = 1, or word with addr[1:0] != 0.
  - The access is suppressed: no RAM write and no load wait.
  - misalign_out = 1 for one cycle, and wb_RegWrite is forced to 0 for that instruction.
- Stores (in_MemWrite = 1, aligned), single cycle:
  - Byte-enabled write at the clock edge.
  - Byte: lane = addr[1:0], data = rt[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1}, data = rt[15:0], little-endian.
  - Word: all four lanes.
  - MEM/WB captures control and ALU result the same cycle.
- FSM states:
  - IDLE:
    - If in_MemRead and the access is aligned: issue the RAM read, drive stall_out = 1, go to LOAD_WAIT. MEM/WB captures a bubble (wb_RegWrite = 0).
    - Otherwise: MEM/WB captures the inputs; stall_out = 0.
  - LOAD_WAIT:
    - stall_out = 0.
    - Lane-select the RAM word and extend it: byte is sign-extended, half is sign-extended, word passes through.
    - wb_mem_data receives the extended value; wb_RegWrite, wb_MemToReg, wb_dest and wb_alu_result come from the held inputs.
    - Return to IDLE.
- Inputs are held stable by the upstream stall during LOAD_WAIT. The stage does not latch them.
- Simultaneous in_MemRead and in_MemWrite:
  - The store is performed in the IDLE cycle. The read is issued in the same cycle with write-first semantics, and the load returns the newly written data.
  - The stall and timing match a plain load.
- Reset asserted during LOAD_WAIT: the load is discarded, the FSM returns to IDLE, and the MEM/WB registers are cleared.
- Throughput:
  - Non-load instructions: one per cycle.
  - Loads: one every 2 cycles.
  - Back-to-back loads each stall.

Decomposition:
- Shared package mips_pkg:
  - load_mode encodings LM_BYTE = 0, LM_HALF = 1, LM_WORD = 2.
  - FSM state enum: IDLE, LOAD_WAIT.
- One sub-module, data_mem:
  - DEPTH x 32 synchronous-read, write-first RAM with a 4-bit byte enable.
  - Ports: clk, we[3:0], addr, wdata, rdata.
  - Extension and lane logic stay in mem_stage.

Test Plan:
- Reset mid-operation: assert rst_n = 0 during LOAD_WAIT -> all wb_* = 0, misalign_out = 0, stall_out = 0 after release; the next instruction proceeds normally.
- Word store then load: store rt = 0xDEADBEEF at addr 0x10 (word). Next, load word from 0x10 -> stall_out = 1 for one cycle, then wb_mem_data = 0xDEADBEEF, wb_RegWrite = 1, wb_MemToReg = 1, wb_dest = 9.
- Sign extension:
  - Load byte at 0x13 (byte 0xDE) -> 0xFFFFFFDE.
  - Load half at 0x10 (half 0xBEEF) -> 0xFFFFBEEF.
  - Store byte 0x7F to 0x11, then load byte -> 0x0000007F; the other lanes are unchanged (word reads 0xDEAD7FEF).
- Misaligned access: load half at 0x11 -> no stall, misalign_out = 1 for one cycle, wb_RegWrite = 0. Store word to 0x12 -> memory is unchanged.
- Branch:
  - in_branch = 1, in_zero = 1, in_pc = 128 -> pc_src_out = 1, branch_target_out = 128.
  - in_zero = 0 -> pc_src_out = 0.
- Simultaneous store and load: MemWrite = MemRead = 1, word, addr 0x20, rt = 8 -> stall for one cycle, then wb_mem_data = 8.
- Non-memory ALU op: RegWrite = 1, dest = 5, aluResult = 30 -> next edge wb_alu_result = 30, wb_dest = 5, wb_MemToReg = 0, no stall.
